// File: rtl/x_sequencer_pkg.sv
// x_sequencer_pkg: shared constants and state encoding for the input-vector
// sequencer. The ROM and the LSTM top use the same default dimensions.
package x_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH          = 32;  // bits per element / ROM addr
    localparam int unsigned DEFAULT_NUM            = 68;  // features + bias slot
    localparam int unsigned DEFAULT_NUM_ITERATIONS = 8;   // timesteps per sequence

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StWait,
        StFin
    } seq_state_e;

    // Width of the timestep index; a single-step sequence still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/x_vec_reg.sv
// x_vec_reg: load-enable register holding the input vector presented to the
// LSTM cell.
//   clk  - clock
//   rst  - synchronous active-high reset, clears the vector
//   load - capture d on the next rising edge
//   d    - vector to capture (ROM read data)
//   q    - registered vector
module x_vec_reg #(
    parameter int unsigned W = 2176
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/x_sequencer.sv
// x_sequencer: walks the input-vector ROM from address 0 to NUM_ITERATIONS-1,
// registers each vector and hands it to the LSTM cell over valid/ready, then
// waits for the cell's step_done before fetching the next one.
//   clk, rst         - clock, synchronous active-high reset
//   start            - run one sequence (sampled only while idle)
//   addr / mem_data  - ROM address out, combinational ROM data in
//   x_out            - registered vector, qualified by x_valid / x_first / x_last
//   x_ready          - cell accepts x_out
//   step_done        - cell finished the accepted timestep
//   step_idx         - current timestep index
//   busy, done       - not idle; one-cycle sequence-complete pulse
module x_sequencer
    import x_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned NUM            = DEFAULT_NUM,
    parameter int unsigned NUM_ITERATIONS = DEFAULT_NUM_ITERATIONS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic [WIDTH-1:0]                       addr,
    input  logic [WIDTH*NUM-1:0]                   mem_data,
    output logic [WIDTH*NUM-1:0]                   x_out,
    output logic                                   x_valid,
    input  logic                                   x_ready,
    output logic                                   x_first,
    output logic                                   x_last,
    input  logic                                   step_done,
    output logic [idx_width(NUM_ITERATIONS)-1:0]   step_idx,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned IDX_W = idx_width(NUM_ITERATIONS);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              first_q, last_q;
    logic              load;
    logic              is_last;

    assign is_last = (idx_q == IDX_W'(NUM_ITERATIONS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Flags are captured together with the vector so they stay aligned.
            if (load) begin
                first_q <= (idx_q == '0);
                last_q  <= is_last;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                load    = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (x_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (step_done) begin
                    if (is_last) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StFetch;
                    end
                end
            end
            StFin: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    x_vec_reg #(
        .W (WIDTH * NUM)
    ) u_x_vec_reg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d    (mem_data),
        .q    (x_out)
    );

    assign addr     = WIDTH'(idx_q);
    assign step_idx = idx_q;
    assign x_valid  = (state_q == StSend);
    assign x_first  = first_q;
    assign x_last   = last_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);

endmodule

// File: tb/tb_x_sequencer.sv
// tb_x_sequencer: scoreboard bench for x_sequencer (8-step instance) plus a
// single-step instance for the NUM_ITERATIONS=1 corner.
module tb_x_sequencer;

    localparam int W  = 32;
    localparam int N  = 68;
    localparam int VW = W * N;

    typedef struct {
        int   k;
        logic first;
        logic last;
    } exp_t;

    typedef struct {
        logic [VW-1:0] vec;
        logic          first;
        logic          last;
        int            cyc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          x_ready = 1'b0;
    logic          step_done = 1'b0;
    logic [W-1:0]  addr;
    logic [VW-1:0] mem_data, x_out;
    logic          x_valid, x_first, x_last, busy, done;
    logic [2:0]    step_idx;

    logic          start1 = 1'b0;
    logic          x_ready1 = 1'b0;
    logic          step_done1 = 1'b0;
    logic [W-1:0]  addr1;
    logic [VW-1:0] mem_data1, x_out1;
    logic          x_valid1, x_first1, x_last1, busy1, done1;
    logic [0:0]    step_idx1;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   unstable = 0;
    int   stall_cycles = 0;
    int   last_sd_cyc = -1;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   done_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] make_vec(input int k);
        logic [VW-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = W'(k * 32'h100 + j);
        return v;
    endfunction

    always_comb begin
        mem_data = '0;
        for (int j = 0; j < N; j++) mem_data[j*W +: W] = addr * 32'h100 + W'(j);
    end

    always_comb begin
        mem_data1 = '0;
        for (int j = 0; j < N; j++) mem_data1[j*W +: W] = addr1 * 32'h100 + W'(j);
    end

    x_sequencer #(.WIDTH(W), .NUM(N), .NUM_ITERATIONS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .mem_data(mem_data),
        .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready), .x_first(x_first),
        .x_last(x_last), .step_done(step_done), .step_idx(step_idx), .busy(busy),
        .done(done)
    );

    x_sequencer #(.WIDTH(W), .NUM(N), .NUM_ITERATIONS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .addr(addr1), .mem_data(mem_data1),
        .x_out(x_out1), .x_valid(x_valid1), .x_ready(x_ready1), .x_first(x_first1),
        .x_last(x_last1), .step_done(step_done1), .step_idx(step_idx1), .busy(busy1),
        .done(done1)
    );

    task automatic push_seq(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{k, (k == 0), (k == n - 1)});
    endtask

    // Pulse start across one rising edge; returns the cycle it was raised in.
    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // LSTM cell model: records each accepted vector and every done pulse,
    // answers each accept with step_done 4 cycles later. Performs no checks.
    task automatic serve(input int want_done, input int stall_vec, input bit spur_sd,
                         input bit spur_start, input int rst_vec);
        int            cnt = 0;
        int            n_done = 0;
        int            n_acc = 0;
        int            stall_left = 5;
        bit            have_snap = 1'b0;
        logic [VW-1:0] snap;
        logic          sf, sl;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            step_done = 1'b0;
            if (spur_start) start = (n_acc == 4 && cnt == 3);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    step_done   = 1'b1;
                    last_sd_cyc = cyc;
                end
            end
            if (done) begin
                done_cyc_q.push_back(cyc);
                n_done++;
                if (n_done == want_done) return;
            end
            if (rst_vec >= 0 && n_acc == rst_vec + 1 && cnt == 2) begin
                rst       = 1'b1;
                step_done = 1'b0;
                return;
            end
            if (x_valid) begin
                if (!have_snap) begin
                    snap = x_out; sf = x_first; sl = x_last; have_snap = 1'b1;
                end else if (x_out !== snap || x_first !== sf || x_last !== sl) begin
                    unstable++;
                end
                x_ready = !(n_acc == stall_vec && stall_left > 0);
                if (!x_ready) begin
                    stall_left--;
                    stall_cycles++;
                end else begin
                    obs_q.push_back('{x_out, x_first, x_last, cyc});
                    n_acc++;
                    cnt       = 4;
                    have_snap = 1'b0;
                    if (spur_sd) step_done = 1'b1;
                end
            end else begin
                x_ready = 1'b1;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        done_cyc_q.delete();
        unstable     = 0;
        stall_cycles = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({addr, step_idx, x_valid, x_first, x_last, busy, done} !== '0 || x_out !== '0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: outs=%h x_out0=%h, want all 0", i,
                         {addr, step_idx, x_valid, x_first, x_last, busy, done}, x_out[W-1:0]);
            end
        end
    endtask

    task automatic test_full_sequence();
        int   s;
        exp_t e;
        obs_t o;
        clear_sb();
        push_seq(8);
        pulse_start(s);
        serve(1, -1, 1'b0, 1'b0, -1);
        n_tests++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL full_count: got %0d vectors, want 8", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            n_tests++;
            if (obs_q[0].cyc != s + 2) begin
                n_fail++;
                $display("FAIL full_first_valid: cycle %0d, want %0d", obs_q[0].cyc, s + 2);
            end
        end
        for (int i = 1; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i].cyc - obs_q[i-1].cyc != 6) begin
                n_fail++;
                $display("FAIL full_spacing%0d: %0d cycles, want 6", i,
                         obs_q[i].cyc - obs_q[i-1].cyc);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o.vec !== make_vec(e.k) || o.first !== e.first || o.last !== e.last) begin
                n_fail++;
                $display("FAIL full_vec%0d: elem0=%h f=%b l=%b, want elem0=%h f=%b l=%b", e.k,
                         o.vec[W-1:0], o.first, o.last, e.k * 256, e.first, e.last);
            end
        end
        n_tests++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != last_sd_cyc + 1) begin
            n_fail++;
            $display("FAIL full_done: %0d pulses, want 1 at cycle %0d", done_cyc_q.size(),
                     last_sd_cyc + 1);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_busy_fall: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        int   s;
        exp_t e;
        obs_t o;
        clear_sb();
        push_seq(8);
        pulse_start(s);
        serve(1, 3, 1'b0, 1'b0, -1);
        n_tests++;
        if (obs_q.size() != 8 || stall_cycles != 5 || unstable != 0) begin
            n_fail++;
            $display("FAIL bp_accept: accepts=%0d stalls=%0d unstable=%0d, want 8 5 0",
                     obs_q.size(), stall_cycles, unstable);
        end
        if (obs_q.size() == 8) begin
            n_tests++;
            if (obs_q[3].cyc - obs_q[2].cyc != 11) begin
                n_fail++;
                $display("FAIL bp_delay: %0d cycles, want 11", obs_q[3].cyc - obs_q[2].cyc);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o.vec !== make_vec(e.k) || o.first !== e.first || o.last !== e.last) begin
                n_fail++;
                $display("FAIL bp_vec%0d: elem0=%h f=%b l=%b, want elem0=%h f=%b l=%b", e.k,
                         o.vec[W-1:0], o.first, o.last, e.k * 256, e.first, e.last);
            end
        end
        n_tests++;
        if (done_cyc_q.size() != 1) begin
            n_fail++;
            $display("FAIL bp_done: %0d pulses, want 1", done_cyc_q.size());
        end
    endtask

    task automatic test_spurious();
        int   s;
        exp_t e;
        obs_t o;
        clear_sb();
        repeat (2) @(negedge clk);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        n_tests++;
        if (step_idx !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_idle_step: idx=%0d busy=%b, want 0 0", step_idx, busy);
        end
        push_seq(8);
        pulse_start(s);
        serve(1, -1, 1'b1, 1'b1, -1);
        start = 1'b0;
        n_tests++;
        if (obs_q.size() != 8 || done_cyc_q.size() != 1) begin
            n_fail++;
            $display("FAIL spur_count: accepts=%0d dones=%0d, want 8 1", obs_q.size(),
                     done_cyc_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o.vec !== make_vec(e.k) || o.first !== e.first || o.last !== e.last) begin
                n_fail++;
                $display("FAIL spur_vec%0d: elem0=%h f=%b l=%b, want elem0=%h f=%b l=%b", e.k,
                         o.vec[W-1:0], o.first, o.last, e.k * 256, e.first, e.last);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   s;
        exp_t e;
        obs_t o;
        clear_sb();
        pulse_start(s);
        serve(1, -1, 1'b0, 1'b0, 5);
        @(negedge clk);
        n_tests++;
        if ({addr, step_idx, x_valid, x_first, x_last, busy, done} !== '0 || x_out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outs: outs=%h x_out0=%h, want all 0",
                     {addr, step_idx, x_valid, x_first, x_last, busy, done}, x_out[W-1:0]);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_cyc_q.push_back(cyc);
        end
        n_tests++;
        if (obs_q.size() != 6 || done_cyc_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_abandon: accepts=%0d dones=%0d, want 6 0", obs_q.size(),
                     done_cyc_q.size());
        end
        clear_sb();
        push_seq(8);
        pulse_start(s);
        n_tests++;
        if (addr !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_refetch: addr=%0d busy=%b, want 0 1", addr, busy);
        end
        serve(1, -1, 1'b0, 1'b0, -1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o.vec !== make_vec(e.k) || o.first !== e.first || o.last !== e.last) begin
                n_fail++;
                $display("FAIL rst_vec%0d: elem0=%h f=%b l=%b, want elem0=%h f=%b l=%b", e.k,
                         o.vec[W-1:0], o.first, o.last, e.k * 256, e.first, e.last);
            end
        end
        n_tests++;
        if (done_cyc_q.size() != 1) begin
            n_fail++;
            $display("FAIL rst_done: %0d pulses, want 1", done_cyc_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   s;
        exp_t e;
        obs_t o;
        clear_sb();
        push_seq(8);
        push_seq(8);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        serve(2, -1, 1'b0, 1'b0, -1);
        start = 1'b0;
        n_tests++;
        if (obs_q.size() != 16 || done_cyc_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d dones=%0d, want 16 2", obs_q.size(),
                     done_cyc_q.size());
        end
        if (obs_q.size() == 16 && done_cyc_q.size() == 2) begin
            n_tests++;
            if (obs_q[8].cyc != done_cyc_q[0] + 3 || obs_q[0].cyc != s + 2) begin
                n_fail++;
                $display("FAIL b2b_restart: seq2 valid at %0d, want %0d", obs_q[8].cyc,
                         done_cyc_q[0] + 3);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o.vec !== make_vec(e.k) || o.first !== e.first || o.last !== e.last) begin
                n_fail++;
                $display("FAIL b2b_vec%0d: elem0=%h f=%b l=%b, want elem0=%h f=%b l=%b", e.k,
                         o.vec[W-1:0], o.first, o.last, e.k * 256, e.first, e.last);
            end
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_single_step();
        bit seen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = x_valid1;
        end
        n_tests++;
        if (!seen || x_first1 !== 1'b1 || x_last1 !== 1'b1 || x_out1 !== make_vec(0)) begin
            n_fail++;
            $display("FAIL single_vec: valid=%b f=%b l=%b elem0=%h, want 1 1 1 0", seen,
                     x_first1, x_last1, x_out1[W-1:0]);
        end
        x_ready1 = 1'b1;
        @(negedge clk);
        x_ready1 = 1'b0;
        @(negedge clk);
        step_done1 = 1'b1;
        @(negedge clk);
        step_done1 = 1'b0;
        n_tests++;
        if (done1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done: done=%b, want 1", done1);
        end
        @(negedge clk);
        n_tests++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: done=%b busy=%b, want 0 0", done1, busy1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_sequence();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        test_single_step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
